// File: rtl/ahbl_pkg.sv
// rtl/ahbl_pkg.sv - AHB-Lite encodings shared by the 2x1 master arbiter
package ahbl_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  // Which upstream port owns the bus data phase
  typedef enum logic [1:0] {
    DOWNER_NONE = 2'b00,
    DOWNER_P0   = 2'b01,
    DOWNER_P1   = 2'b10
  } downer_e;

endpackage

// File: rtl/ahbl_master_arbiter_2x1_if.sv
// rtl/ahbl_master_arbiter_2x1_if.sv - AHB-Lite bus bundle; master drives address/data, slave drives ready/read data
interface ahbl_master_arbiter_2x1_if #(
  parameter int AW = 32
);
  logic [AW-1:0] HADDR;
  logic [1:0]    HTRANS;
  logic          HWRITE;
  logic [2:0]    HSIZE;
  logic [31:0]   HWDATA;
  logic          HREADY;
  logic [31:0]   HRDATA;

  modport master (output HADDR, HTRANS, HWRITE, HSIZE, HWDATA, input HREADY, HRDATA);
  modport slave  (input HADDR, HTRANS, HWRITE, HSIZE, HWDATA, output HREADY, HRDATA);
endinterface

// File: rtl/ahbl_arb_in_stage.sv
// rtl/ahbl_arb_in_stage.sv - per-port input stage: address holding register, pending flag, HREADY stall
module ahbl_arb_in_stage
  import ahbl_pkg::*;
#(
  parameter int AW = 32
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  ahbl_master_arbiter_2x1_if.slave  bus,
  input  logic                      grant_i,
  input  logic                      owner_i,
  input  logic                      m_hready_i,
  input  logic [31:0]               m_hrdata_i,
  output logic                      eff_o,
  output logic [AW-1:0]             haddr_o,
  output logic                      hwrite_o,
  output logic [2:0]                hsize_o
);
  logic          pend_q, pend_d;
  logic [AW-1:0] haddr_q, haddr_d;
  logic          hwrite_q, hwrite_d;
  logic [2:0]    hsize_q, hsize_d;
  logic          hready;
  logic          req;

  always_comb begin
    hready = 1'b1;
    if (owner_i) begin
      hready = m_hready_i;
    end else if (pend_q) begin
      hready = 1'b0;
    end
  end

  assign bus.HREADY = hready;
  assign bus.HRDATA = m_hrdata_i;

  // Requests are ignored while in reset so nothing leaks onto the bus
  assign req   = HRESETn & bus.HTRANS[1] & hready;
  assign eff_o = pend_q | req;

  always_comb begin
    pend_d   = pend_q;
    haddr_d  = haddr_q;
    hwrite_d = hwrite_q;
    hsize_d  = hsize_q;
    if (req && !grant_i) begin
      pend_d   = 1'b1;
      haddr_d  = bus.HADDR;
      hwrite_d = bus.HWRITE;
      hsize_d  = bus.HSIZE;
    end else if (grant_i) begin
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      pend_q   <= 1'b0;
      haddr_q  <= '0;
      hwrite_q <= 1'b0;
      hsize_q  <= HSIZE_BYTE;
    end else begin
      pend_q   <= pend_d;
      haddr_q  <= haddr_d;
      hwrite_q <= hwrite_d;
      hsize_q  <= hsize_d;
    end
  end

  assign haddr_o  = pend_q ? haddr_q  : bus.HADDR;
  assign hwrite_o = pend_q ? hwrite_q : bus.HWRITE;
  assign hsize_o  = pend_q ? hsize_q  : bus.HSIZE;

endmodule

// File: rtl/ahbl_master_arbiter_2x1.sv
// rtl/ahbl_master_arbiter_2x1.sv - merges CPU (port 0) and DMAC (port 1) AHB-Lite masters onto one bus
module ahbl_master_arbiter_2x1
  import ahbl_pkg::*;
#(
  parameter int ARB_MODE = 1,
  parameter int AW       = 32
) (
  input  logic                       HCLK,
  input  logic                       HRESETn,
  ahbl_master_arbiter_2x1_if.slave   s0_if,
  ahbl_master_arbiter_2x1_if.slave   s1_if,
  ahbl_master_arbiter_2x1_if.master  m_if,
  output logic                       M_HMASTER
);
  logic          eff0, eff1;
  logic          gnt0, gnt1, any_gnt;
  logic [AW-1:0] addr0, addr1;
  logic          wr0, wr1;
  logic [2:0]    sz0, sz1;
  logic          last_grant_q, last_grant_d;
  logic          hmaster_q, hmaster_d;
  downer_e       downer_q, downer_d;
  logic [AW-1:0] m_haddr;
  logic [1:0]    m_htrans;
  logic          m_hwrite;
  logic [2:0]    m_hsize;
  logic [31:0]   m_hwdata;

  ahbl_arb_in_stage #(.AW(AW)) u_in0 (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .bus        (s0_if),
    .grant_i    (gnt0),
    .owner_i    (downer_q == DOWNER_P0),
    .m_hready_i (m_if.HREADY),
    .m_hrdata_i (m_if.HRDATA),
    .eff_o      (eff0),
    .haddr_o    (addr0),
    .hwrite_o   (wr0),
    .hsize_o    (sz0)
  );

  ahbl_arb_in_stage #(.AW(AW)) u_in1 (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .bus        (s1_if),
    .grant_i    (gnt1),
    .owner_i    (downer_q == DOWNER_P1),
    .m_hready_i (m_if.HREADY),
    .m_hrdata_i (m_if.HRDATA),
    .eff_o      (eff1),
    .haddr_o    (addr1),
    .hwrite_o   (wr1),
    .hsize_o    (sz1)
  );

  // Grant only while the bus accepts an address; on conflict round-robin favours the port not served last
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (m_if.HREADY) begin
      if (eff0 && eff1) begin
        if (ARB_MODE == 0 || last_grant_q) begin
          gnt0 = 1'b1;
        end else begin
          gnt1 = 1'b1;
        end
      end else begin
        gnt0 = eff0;
        gnt1 = eff1;
      end
    end
  end

  assign any_gnt = gnt0 | gnt1;

  always_comb begin
    last_grant_d = any_gnt ? gnt1 : last_grant_q;
    hmaster_d    = any_gnt ? gnt1 : hmaster_q;
    downer_d     = downer_q;
    if (m_if.HREADY) begin
      if (gnt0) begin
        downer_d = DOWNER_P0;
      end else if (gnt1) begin
        downer_d = DOWNER_P1;
      end else begin
        downer_d = DOWNER_NONE;
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      last_grant_q <= 1'b1;
      hmaster_q    <= 1'b0;
      downer_q     <= DOWNER_NONE;
    end else begin
      last_grant_q <= last_grant_d;
      hmaster_q    <= hmaster_d;
      downer_q     <= downer_d;
    end
  end

  always_comb begin
    m_htrans = HTRANS_IDLE;
    m_haddr  = '0;
    m_hwrite = 1'b0;
    m_hsize  = HSIZE_BYTE;
    m_hwdata = 32'h0;
    if (gnt0) begin
      m_htrans = HTRANS_NONSEQ;
      m_haddr  = addr0;
      m_hwrite = wr0;
      m_hsize  = sz0;
    end else if (gnt1) begin
      m_htrans = HTRANS_NONSEQ;
      m_haddr  = addr1;
      m_hwrite = wr1;
      m_hsize  = sz1;
    end
    case (downer_q)
      DOWNER_P0: m_hwdata = s0_if.HWDATA;
      DOWNER_P1: m_hwdata = s1_if.HWDATA;
      default:   m_hwdata = 32'h0;
    endcase
  end

  assign m_if.HTRANS = m_htrans;
  assign m_if.HADDR  = m_haddr;
  assign m_if.HWRITE = m_hwrite;
  assign m_if.HSIZE  = m_hsize;
  assign m_if.HWDATA = m_hwdata;
  assign M_HMASTER   = any_gnt ? gnt1 : hmaster_q;

endmodule

// File: tb/tb_ahbl_master_arbiter_2x1.sv
// tb/tb_ahbl_master_arbiter_2x1.sv - directed bench for the 2x1 AHB-Lite master arbiter
module tb_ahbl_master_arbiter_2x1;
  import ahbl_pkg::*;

  logic HCLK;
  logic HRESETn;
  logic M_HMASTER;
  logic fp_hmaster;
  logic slave_ready;
  int   n_run;
  int   n_fail;

  ahbl_master_arbiter_2x1_if #(.AW(32)) s0 ();
  ahbl_master_arbiter_2x1_if #(.AW(32)) s1 ();
  ahbl_master_arbiter_2x1_if #(.AW(32)) m ();
  ahbl_master_arbiter_2x1_if #(.AW(32)) fs0 ();
  ahbl_master_arbiter_2x1_if #(.AW(32)) fs1 ();
  ahbl_master_arbiter_2x1_if #(.AW(32)) fm ();

  ahbl_master_arbiter_2x1 #(.ARB_MODE(1), .AW(32)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .s0_if(s0), .s1_if(s1), .m_if(m), .M_HMASTER(M_HMASTER)
  );

  ahbl_master_arbiter_2x1 #(.ARB_MODE(0), .AW(32)) dut_fp (
    .HCLK(HCLK), .HRESETn(HRESETn), .s0_if(fs0), .s1_if(fs1), .m_if(fm), .M_HMASTER(fp_hmaster)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // Memory slave behind the round-robin instance; initial content is 0xC0DE0000 + word index
  logic [31:0] mem [0:255];
  logic        dp_valid, dp_write;
  logic [7:0]  dp_idx;
  int          cnt0, cnt1;

  assign m.HREADY  = slave_ready;
  assign m.HRDATA  = mem[dp_idx];
  assign fm.HREADY = 1'b1;
  assign fm.HRDATA = 32'h0;

  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hC0DE_0000 + 32'(i);
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_idx   <= 8'd0;
      cnt0     <= 0;
      cnt1     <= 0;
    end else if (slave_ready) begin
      if (dp_valid && dp_write) mem[dp_idx] <= m.HWDATA;
      dp_valid <= m.HTRANS[1];
      dp_write <= m.HWRITE;
      dp_idx   <= m.HADDR[9:2];
      if (m.HTRANS[1]) begin
        if (M_HMASTER) cnt1 <= cnt1 + 1;
        else cnt0 <= cnt0 + 1;
      end
    end
  end

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic drive0(input logic [1:0] t, input logic [31:0] a, input logic w, input logic [31:0] wd);
    s0.HTRANS = t; s0.HADDR = a; s0.HWRITE = w; s0.HSIZE = HSIZE_WORD; s0.HWDATA = wd;
  endtask

  task automatic drive1(input logic [1:0] t, input logic [31:0] a, input logic w, input logic [31:0] wd);
    s1.HTRANS = t; s1.HADDR = a; s1.HWRITE = w; s1.HSIZE = HSIZE_WORD; s1.HWDATA = wd;
  endtask

  task automatic drive_fp(input logic [1:0] t0, input logic [1:0] t1);
    fs0.HTRANS = t0; fs0.HADDR = 32'h10; fs0.HWRITE = 1'b0; fs0.HSIZE = HSIZE_WORD; fs0.HWDATA = 32'h0;
    fs1.HTRANS = t1; fs1.HADDR = 32'h20; fs1.HWRITE = 1'b0; fs1.HSIZE = HSIZE_WORD; fs1.HWDATA = 32'h0;
  endtask

  task automatic do_reset();
    HRESETn = 1'b0;
    slave_ready = 1'b1;
    drive0(HTRANS_IDLE, 32'h0, 1'b0, 32'h0);
    drive1(HTRANS_IDLE, 32'h0, 1'b0, 32'h0);
    drive_fp(HTRANS_IDLE, HTRANS_IDLE);
    repeat (2) @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
  endtask

  task automatic test_reset();
    HRESETn = 1'b0;
    slave_ready = 1'b1;
    drive0(HTRANS_IDLE, 32'h0, 1'b0, 32'h0);
    drive1(HTRANS_IDLE, 32'h0, 1'b0, 32'h0);
    drive_fp(HTRANS_IDLE, HTRANS_IDLE);
    repeat (2) @(posedge HCLK);
    #1;
    n_run++; if (s0.HREADY !== 1'b1) begin n_fail++; $display("FAIL rst_s0_hready got %b exp 1", s0.HREADY); end
    n_run++; if (s1.HREADY !== 1'b1) begin n_fail++; $display("FAIL rst_s1_hready got %b exp 1", s1.HREADY); end
    n_run++; if (m.HTRANS !== HTRANS_IDLE) begin n_fail++; $display("FAIL rst_htrans got %h exp 0", m.HTRANS); end
    n_run++; if (M_HMASTER !== 1'b0) begin n_fail++; $display("FAIL rst_hmaster got %b exp 0", M_HMASTER); end
    n_run++; if (m.HADDR !== 32'h0) begin n_fail++; $display("FAIL rst_haddr got %h exp 0", m.HADDR); end
    n_run++; if (m.HWDATA !== 32'h0) begin n_fail++; $display("FAIL rst_hwdata got %h exp 0", m.HWDATA); end
    HRESETn = 1'b1;
  endtask

  task automatic test_single_write();
    do_reset();
    drive1(HTRANS_NONSEQ, 32'h2000_0010, 1'b1, 32'h0);
    #1;
    n_run++; if (m.HTRANS !== HTRANS_NONSEQ) begin n_fail++; $display("FAIL t1_htrans got %h exp 2", m.HTRANS); end
    n_run++; if (m.HADDR !== 32'h2000_0010) begin n_fail++; $display("FAIL t1_haddr got %h exp 20000010", m.HADDR); end
    n_run++; if (M_HMASTER !== 1'b1) begin n_fail++; $display("FAIL t1_hmaster got %b exp 1", M_HMASTER); end
    n_run++; if (m.HWRITE !== 1'b1 || m.HSIZE !== HSIZE_WORD) begin n_fail++; $display("FAIL t1_ctrl got w=%b s=%h exp w=1 s=2", m.HWRITE, m.HSIZE); end
    n_run++; if (s1.HREADY !== 1'b1) begin n_fail++; $display("FAIL t1_s1_hready_a got %b exp 1", s1.HREADY); end
    step();
    drive1(HTRANS_IDLE, 32'h0, 1'b0, 32'hA5A5_A5A5);
    #1;
    n_run++; if (m.HWDATA !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL t1_hwdata got %h exp a5a5a5a5", m.HWDATA); end
    n_run++; if (s1.HREADY !== 1'b1) begin n_fail++; $display("FAIL t1_s1_hready_d got %b exp 1", s1.HREADY); end
    n_run++; if (m.HTRANS !== HTRANS_IDLE || M_HMASTER !== 1'b1) begin n_fail++; $display("FAIL t1_idle got t=%h hm=%b exp t=0 hm=1", m.HTRANS, M_HMASTER); end
    step();
    n_run++; if (mem[4] !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL t1_mem got %h exp a5a5a5a5", mem[4]); end
  endtask

  task automatic test_conflict();
    do_reset();
    drive0(HTRANS_NONSEQ, 32'h100, 1'b0, 32'h0);
    drive1(HTRANS_NONSEQ, 32'h200, 1'b0, 32'h0);
    #1;
    n_run++; if (m.HADDR !== 32'h100 || M_HMASTER !== 1'b0) begin n_fail++; $display("FAIL t2_first got a=%h hm=%b exp a=100 hm=0", m.HADDR, M_HMASTER); end
    step();
    drive0(HTRANS_IDLE, 32'h0, 1'b0, 32'h0);
    drive1(HTRANS_IDLE, 32'h0, 1'b0, 32'h0);
    #1;
    n_run++; if (m.HADDR !== 32'h200 || m.HTRANS !== HTRANS_NONSEQ || M_HMASTER !== 1'b1) begin n_fail++; $display("FAIL t2_held got a=%h t=%h hm=%b exp a=200 t=2 hm=1", m.HADDR, m.HTRANS, M_HMASTER); end
    n_run++; if (s1.HREADY !== 1'b0) begin n_fail++; $display("FAIL t2_s1_stall got %b exp 0", s1.HREADY); end
    n_run++; if (s0.HREADY !== 1'b1 || s0.HRDATA !== 32'hC0DE_0040) begin n_fail++; $display("FAIL t2_s0_read got r=%b d=%h exp r=1 d=c0de0040", s0.HREADY, s0.HRDATA); end
    step();
    n_run++; if (s1.HREADY !== 1'b1 || s1.HRDATA !== 32'hC0DE_0080) begin n_fail++; $display("FAIL t2_s1_read got r=%b d=%h exp r=1 d=c0de0080", s1.HREADY, s1.HRDATA); end
    n_run++; if (m.HTRANS !== HTRANS_IDLE) begin n_fail++; $display("FAIL t2_idle got %h exp 0", m.HTRANS); end
  endtask

  task automatic test_wait_states();
    do_reset();
    drive0(HTRANS_NONSEQ, 32'h104, 1'b0, 32'h0);
    step();
    slave_ready = 1'b0;
    drive0(HTRANS_IDLE, 32'h0, 1'b0, 32'h0);
    drive1(HTRANS_NONSEQ, 32'h204, 1'b0, 32'h0);
    #1;
    n_run++; if (m.HTRANS !== HTRANS_IDLE || s0.HREADY !== 1'b0) begin n_fail++; $display("FAIL t3_wait0 got t=%h r0=%b exp t=0 r0=0", m.HTRANS, s0.HREADY); end
    for (int k = 0; k < 2; k++) begin
      step();
      drive1(HTRANS_IDLE, 32'h0, 1'b0, 32'h0);
      #1;
      n_run++; if (m.HTRANS !== HTRANS_IDLE || s1.HREADY !== 1'b0 || dut.u_in1.pend_q !== 1'b1) begin n_fail++; $display("FAIL t3_hold%0d got t=%h r1=%b p1=%b exp t=0 r1=0 p1=1", k, m.HTRANS, s1.HREADY, dut.u_in1.pend_q); end
    end
    step();
    slave_ready = 1'b1;
    #1;
    n_run++; if (s0.HREADY !== 1'b1 || s0.HRDATA !== 32'hC0DE_0041) begin n_fail++; $display("FAIL t3_s0_done got r=%b d=%h exp r=1 d=c0de0041", s0.HREADY, s0.HRDATA); end
    n_run++; if (m.HTRANS !== HTRANS_NONSEQ || m.HADDR !== 32'h204 || M_HMASTER !== 1'b1) begin n_fail++; $display("FAIL t3_grant got t=%h a=%h hm=%b exp t=2 a=204 hm=1", m.HTRANS, m.HADDR, M_HMASTER); end
    n_run++; if (s1.HREADY !== 1'b0 || dut.u_in1.pend_q !== 1'b1) begin n_fail++; $display("FAIL t3_s1_pend got r=%b p=%b exp r=0 p=1", s1.HREADY, dut.u_in1.pend_q); end
    step();
    n_run++; if (s1.HREADY !== 1'b1 || s1.HRDATA !== 32'hC0DE_0081 || dut.u_in1.pend_q !== 1'b0) begin n_fail++; $display("FAIL t3_s1_done got r=%b d=%h p=%b exp r=1 d=c0de0081 p=0", s1.HREADY, s1.HRDATA, dut.u_in1.pend_q); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive0(HTRANS_NONSEQ, 32'h10, 1'b0, 32'h0);
    drive1(HTRANS_NONSEQ, 32'h20, 1'b0, 32'h0);
    drive_fp(HTRANS_NONSEQ, HTRANS_NONSEQ);
    for (int k = 0; k < 8; k++) begin
      if (k > 0) step();
      #1;
      n_run++; if (m.HTRANS !== HTRANS_NONSEQ || M_HMASTER !== 1'(k % 2) || m.HADDR !== ((k % 2) ? 32'h20 : 32'h10)) begin n_fail++; $display("FAIL t4_rr%0d got t=%h hm=%b a=%h exp t=2 hm=%0d", k, m.HTRANS, M_HMASTER, m.HADDR, k % 2); end
      n_run++; if (fm.HTRANS !== HTRANS_NONSEQ || fp_hmaster !== 1'b0 || fs1.HREADY !== (k == 0)) begin n_fail++; $display("FAIL t4_fp%0d got t=%h hm=%b r1=%b exp t=2 hm=0 r1=%0d", k, fm.HTRANS, fp_hmaster, fs1.HREADY, k == 0); end
    end
    drive0(HTRANS_IDLE, 32'h0, 1'b0, 32'h0);
    drive1(HTRANS_IDLE, 32'h0, 1'b0, 32'h0);
    drive_fp(HTRANS_IDLE, HTRANS_IDLE);
  endtask

  task automatic test_reset_in_flight();
    do_reset();
    drive0(HTRANS_NONSEQ, 32'h108, 1'b0, 32'h0);
    step();
    slave_ready = 1'b0;
    drive0(HTRANS_IDLE, 32'h0, 1'b0, 32'h0);
    drive1(HTRANS_NONSEQ, 32'h208, 1'b0, 32'h0);
    step();
    drive1(HTRANS_IDLE, 32'h0, 1'b0, 32'h0);
    #1;
    n_run++; if (dut.u_in1.pend_q !== 1'b1) begin n_fail++; $display("FAIL t5_pre_pend got %b exp 1", dut.u_in1.pend_q); end
    #1;
    HRESETn = 1'b0;
    #1;
    n_run++; if (s0.HREADY !== 1'b1 || s1.HREADY !== 1'b1) begin n_fail++; $display("FAIL t5_rst_hready got r0=%b r1=%b exp 1 1", s0.HREADY, s1.HREADY); end
    n_run++; if (m.HTRANS !== HTRANS_IDLE || M_HMASTER !== 1'b0) begin n_fail++; $display("FAIL t5_rst_bus got t=%h hm=%b exp t=0 hm=0", m.HTRANS, M_HMASTER); end
    step();
    step();
    slave_ready = 1'b1;
    HRESETn = 1'b1;
    drive1(HTRANS_NONSEQ, 32'h20C, 1'b1, 32'h0);
    #1;
    n_run++; if (m.HTRANS !== HTRANS_NONSEQ || m.HADDR !== 32'h20C || M_HMASTER !== 1'b1 || s1.HREADY !== 1'b1) begin n_fail++; $display("FAIL t5_after got t=%h a=%h hm=%b r1=%b exp t=2 a=20c hm=1 r1=1", m.HTRANS, m.HADDR, M_HMASTER, s1.HREADY); end
    step();
    drive1(HTRANS_IDLE, 32'h0, 1'b0, 32'h5A5A_0001);
    #1;
    n_run++; if (s1.HREADY !== 1'b1 || m.HWDATA !== 32'h5A5A_0001) begin n_fail++; $display("FAIL t5_data got r1=%b wd=%h exp r1=1 wd=5a5a0001", s1.HREADY, m.HWDATA); end
    step();
    n_run++; if (mem[131] !== 32'h5A5A_0001) begin n_fail++; $display("FAIL t5_mem got %h exp 5a5a0001", mem[131]); end
  endtask

  task automatic test_copy_with_poll();
    int          cyc, p1_ap, p1_dp, p1_next, p1_done, p0_done;
    logic        p0_ap, p0_dp, r0, r1;
    logic [31:0] d0, d1, rd_buf;
    do_reset();
    cyc = 0; p1_ap = 0; p1_dp = -1; p1_next = 1; p1_done = 0; p0_done = 0;
    p0_ap = 1'b1; p0_dp = 1'b0; rd_buf = 32'h0;
    while (!(p1_done == 8 && !p0_ap && !p0_dp) && cyc < 300) begin
      slave_ready = (cyc % 3) != 2;
      drive0(p0_ap ? HTRANS_NONSEQ : HTRANS_IDLE, 32'h3F0, 1'b0, 32'h0);
      if (p1_ap >= 0) drive1(HTRANS_NONSEQ, (p1_ap % 2) ? 32'h80 + 32'(4 * (p1_ap / 2)) : 32'(4 * (p1_ap / 2)), 1'(p1_ap % 2), rd_buf);
      else drive1(HTRANS_IDLE, 32'h0, 1'b0, rd_buf);
      @(negedge HCLK);
      r0 = s0.HREADY; d0 = s0.HRDATA; r1 = s1.HREADY; d1 = s1.HRDATA;
      @(posedge HCLK);
      #1;
      if (r0) begin
        if (p0_dp) begin
          p0_done++;
          n_run++; if (d0 !== 32'hC0DE_00FC) begin n_fail++; $display("FAIL t6_poll got %h exp c0de00fc", d0); end
        end
        p0_dp = p0_ap;
        p0_ap = (p1_done < 8);
      end
      if (r1) begin
        if (p1_dp >= 0) begin
          if (p1_dp % 2 == 0) begin
            rd_buf = d1;
            n_run++; if (d1 !== 32'hC0DE_0000 + 32'(p1_dp / 2)) begin n_fail++; $display("FAIL t6_src%0d got %h exp %h", p1_dp / 2, d1, 32'hC0DE_0000 + 32'(p1_dp / 2)); end
          end
          p1_done++;
        end
        p1_dp = p1_ap;
        if (p1_next < 8) begin p1_ap = p1_next; p1_next++; end
        else p1_ap = -1;
      end
      cyc++;
    end
    drive0(HTRANS_IDLE, 32'h0, 1'b0, 32'h0);
    drive1(HTRANS_IDLE, 32'h0, 1'b0, 32'h0);
    n_run++; if (cyc >= 300) begin n_fail++; $display("FAIL t6_timeout got p1_done=%0d exp 8 within 300 cycles", p1_done); end
    for (int i = 0; i < 4; i++) begin
      n_run++; if (mem[32 + i] !== 32'hC0DE_0000 + 32'(i)) begin n_fail++; $display("FAIL t6_dst%0d got %h exp %h", i, mem[32 + i], 32'hC0DE_0000 + 32'(i)); end
    end
    n_run++; if (cnt1 !== 8) begin n_fail++; $display("FAIL t6_bus_p1 got %0d exp 8", cnt1); end
    n_run++; if (cnt0 !== p0_done || p0_done == 0) begin n_fail++; $display("FAIL t6_bus_p0 got %0d exp %0d (nonzero)", cnt0, p0_done); end
  endtask

  initial begin
    n_run = 0;
    n_fail = 0;
    test_reset();
    test_single_write();
    test_conflict();
    test_wait_states();
    test_back_to_back();
    test_reset_in_flight();
    test_copy_with_poll();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
